mandel_iter: RTL and testbench
==============================

// Module: mandel_iter
// PURPOSE
//  Escape-time engine. Consumes one complex point c = (c_re, c_im) per
//  transaction from the pixel-to-plane mapper stage, with that pixel's X/Y.
//  Iterates z <- z^2 + c from z = 0 and returns the escape iteration count,
//  plus the unchanged X/Y and frame-end flag, to the colour/pixel-writer stage.
//  All values are signed fixed-point Q10.21 (1 sign, 10 int, 21 frac bits).
// PARAMETERS
//  MAX_ITER   255   iteration cap; a point still bounded at MAX_ITER reports MAX_ITER
//  ITER_W     8     count width; must satisfy MAX_ITER < 2**ITER_W
// PORTS
//  clock      in   1       single clock; all state updates on rising edge
//  rst        in   1       asynchronous, active-high reset
//  in_valid   in   1       c, x, y and last are valid
//  in_ready   out  1       engine can accept a point
//  c_re       in   32      real part of c, Q10.21
//  c_im       in   32      imaginary part of c, Q10.21
//  x_in       in   10      pixel column
//  y_in       in   10      pixel row
//  last_in    in   1       last pixel of the frame
//  out_valid  out  1       result fields are valid
//  out_ready  in   1       downstream accepts the result
//  iter_cnt   out  ITER_W  escape count
//  escaped    out  1       1 = |z|^2 exceeded 4.0; 0 = cap reached
//  x_out      out  10      captured x_in
//  y_out      out  10      captured y_in
//  last_out   out  1       captured last_in
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1; out_valid=0; iter_cnt, escaped, x_out, y_out,
//    last_out = 0; internal z, c and k = 0. Reset takes effect from any state and
//    discards the in-flight point.
//  - FSM states: IDLE -> ITER -> DONE -> IDLE.
//  - IDLE: in_ready=1. When in_valid=1, capture c, x, y and last, set zr=zi=0 and
//    k=0, and go to ITER.
//  - ITER: in_ready=0. One iteration per cycle. Let m = zr*zr + zi*zi.
//    - If m > 4.0 (strictly greater than 0x0080_0000): iter_cnt=k, escaped=1, go to DONE.
//    - Else if k == MAX_ITER: iter_cnt=MAX_ITER, escaped=0, go to DONE.
//    - Else: zr <= zr*zr - zi*zi + c_re; zi <= 2*(zr*zi) + c_im; k <= k+1.
//  - DONE: out_valid=1. All outputs stay stable while out_ready=0. When
//    out_ready=1, drop out_valid and go to IDLE the next cycle. There is no
//    IDLE/DONE overlap, so there is at most one point in flight.
//  - Latency: the handshake cycle, then (iter_cnt+1) ITER cycles, then out_valid
//    asserts.
//  - Arithmetic:
//    - Products come from three multiplier instances with the codebase
//      Q10.21 truncating semantics (zr*zr, zi*zi, zr*zi).
//    - 2*(zr*zi) is a left shift by 1.
//    - m is formed in 33 bits unsigned so it cannot wrap.
//    - Because escape is tested before every update, |z| <= 2 at each update,
//      so the Q10.21 range never overflows for |c| < 512.
//  - Boundary: |z|^2 exactly 4.0 is not an escape.
//  - in_valid while in_ready=0 is ignored. Upstream must hold its data until
//    the handshake completes.
// STRUCTURE
//  - Shared package (mandel_pkg):
//    - Q10.21 constants FRAC_BITS=21 and ESC_LIMIT=32'h0080_0000.
//    - typedef fixed_t (logic signed [31:0]).
//    - FSM enum state_t {IDLE, ITER, DONE}.
//  - Sub-module: reuse the existing `multiplier`, three instances. No new sub-module.
// TESTING
//  1. c=(0,0), MAX_ITER=255 -> iter_cnt=255, escaped=0; out_valid exactly 257
//     cycles after the accept edge.
//  2. c=(3.0,0)=(0x0060_0000,0) -> iter_cnt=1, escaped=1.
//  3. c=(1.0,0)=(0x0020_0000,0) -> z goes 0,1,2,5; iter_cnt=3, escaped=1.
//  4. c=(-2.0,0)=(0xFFC0_0000,0) -> |z|^2 stays exactly 4.0; iter_cnt=255,
//     escaped=0 (strict-compare boundary).
//  5. x_in=639, y_in=479, last_in=1 with out_ready=0 for 10 cycles -> out_valid
//     and all fields held, in_ready=0; on out_ready=1, in_ready=1 the next cycle
//     and x_out/y_out/last_out = 639/479/1.
//  6. Assert rst mid-ITER for c=(0,0) -> outputs zero immediately; in_ready=1
//     after release; the next point processes normally.

Source files
------------

// File: rtl/mandel_pkg.sv
// Shared definitions for the escape-time engine: Q10.21 fixed-point
// constants, the fixed-point type and the engine FSM encoding.
package mandel_pkg;

    localparam int          FRAC_BITS = 21;
    localparam logic [31:0] ESC_LIMIT = 32'h0080_0000;  // 4.0 in Q10.21

    typedef logic signed [31:0] fixed_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mandel_iter_multiplier.sv
// Q10.21 signed multiplier: full 64-bit product, truncated (floor) back
// to Q10.21 by dropping the low FRAC_BITS fraction bits.
module multiplier
    import mandel_pkg::*;
(
    input  logic signed [31:0] a,
    input  logic signed [31:0] b,
    output logic signed [31:0] p
);

    logic signed [63:0] full_s;

    assign full_s = a * b;
    assign p      = fixed_t'(full_s >>> FRAC_BITS);

endmodule

// File: rtl/mandel_iter.sv
// Escape-time engine: iterates z <- z^2 + c from z = 0, one iteration per
// cycle, and reports the escape count with the pixel's X/Y and frame-end flag.
// One point in flight at a time (IDLE -> ITER -> DONE -> IDLE).
module mandel_iter
    import mandel_pkg::*;
#(
    parameter int MAX_ITER = 255,
    parameter int ITER_W   = 8
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       c_re,
    input  logic [31:0]       c_im,
    input  logic [9:0]        x_in,
    input  logic [9:0]        y_in,
    input  logic              last_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              escaped,
    output logic [9:0]        x_out,
    output logic [9:0]        y_out,
    output logic              last_out
);

    localparam logic [ITER_W-1:0] K_MAX = ITER_W'(MAX_ITER);
    localparam logic [ITER_W-1:0] K_ONE = ITER_W'(1);

    state_t            state_q, state_d;
    fixed_t            zr_q, zr_d, zi_q, zi_d;
    fixed_t            cr_q, cr_d, ci_q, ci_d;
    logic [ITER_W-1:0] k_q, k_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              esc_q, esc_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic              last_q, last_d;

    fixed_t            zr2_s, zi2_s, zri_s;
    logic [32:0]       mag_s;
    logic              over_s;
    logic              at_cap_s;

    multiplier u_mul_rr (.a(zr_q), .b(zr_q), .p(zr2_s));
    multiplier u_mul_ii (.a(zi_q), .b(zi_q), .p(zi2_s));
    multiplier u_mul_ri (.a(zr_q), .b(zi_q), .p(zri_s));

    // Squares are non-negative, so summing them unsigned in 33 bits cannot wrap.
    assign mag_s    = {1'b0, zr2_s} + {1'b0, zi2_s};
    assign over_s   = (mag_s > {1'b0, ESC_LIMIT});   // exactly 4.0 stays bounded
    assign at_cap_s = (k_q == K_MAX);

    // Next-state logic for the IDLE -> ITER -> DONE -> IDLE sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) state_d = ITER;
                else          state_d = IDLE;
            end
            ITER: begin
                if (over_s || at_cap_s) state_d = DONE;
                else                    state_d = ITER;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
                else           state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture the point on accept, iterate z, latch the result on exit.
    always_comb begin
        zr_d   = zr_q;
        zi_d   = zi_q;
        cr_d   = cr_q;
        ci_d   = ci_q;
        k_d    = k_q;
        iter_d = iter_q;
        esc_d  = esc_q;
        x_d    = x_q;
        y_d    = y_q;
        last_d = last_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cr_d   = c_re;
                    ci_d   = c_im;
                    x_d    = x_in;
                    y_d    = y_in;
                    last_d = last_in;
                    zr_d   = 32'sd0;
                    zi_d   = 32'sd0;
                    k_d    = '0;
                end else begin
                    k_d    = k_q;
                end
            end
            ITER: begin
                if (over_s) begin
                    iter_d = k_q;
                    esc_d  = 1'b1;
                end else if (at_cap_s) begin
                    iter_d = K_MAX;
                    esc_d  = 1'b0;
                end else begin
                    zr_d   = zr2_s - zi2_s + cr_q;
                    zi_d   = (zri_s <<< 1) + ci_q;
                    k_d    = k_q + K_ONE;
                end
            end
            DONE: begin
                k_d = k_q;
            end
            default: begin
                k_d = '0;
            end
        endcase
    end

    // Handshake flags decoded from the registered state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            ITER:    in_ready  = 1'b0;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // State, iteration registers and result registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            zr_q    <= 32'sd0;
            zi_q    <= 32'sd0;
            cr_q    <= 32'sd0;
            ci_q    <= 32'sd0;
            k_q     <= '0;
            iter_q  <= '0;
            esc_q   <= 1'b0;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            cr_q    <= cr_d;
            ci_q    <= ci_d;
            k_q     <= k_d;
            iter_q  <= iter_d;
            esc_q   <= esc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            last_q  <= last_d;
        end
    end

    assign iter_cnt = iter_q;
    assign escaped  = esc_q;
    assign x_out    = x_q;
    assign y_out    = y_q;
    assign last_out = last_q;

endmodule

// File: tb/tb_mandel_iter.sv
// Bench for mandel_iter: directed corner points plus random points, with a
// scoreboard fed by the driver and drained by an independent monitor.
module tb_mandel_iter;

    localparam int MAX_ITER = 255;
    localparam longint ONE  = 64'sd2097152;   // 1.0 in Q10.21

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] c_re = 32'd0;
    logic [31:0] c_im = 32'd0;
    logic [9:0]  x_in = 10'd0;
    logic [9:0]  y_in = 10'd0;
    logic        last_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  iter_cnt;
    logic        escaped;
    logic [9:0]  x_out;
    logic [9:0]  y_out;
    logic        last_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         cnt;
        bit         esc;
        logic [9:0] x;
        logic [9:0] y;
        logic       last;
    } exp_t;

    exp_t sb_q[$];

    mandel_iter #(.MAX_ITER(MAX_ITER), .ITER_W(8)) dut (
        .clock     (clock),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c_re      (c_re),
        .c_im      (c_im),
        .x_in      (x_in),
        .y_in      (y_in),
        .last_in   (last_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .iter_cnt  (iter_cnt),
        .escaped   (escaped),
        .x_out     (x_out),
        .y_out     (y_out),
        .last_out  (last_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint wrap32(input longint v);
        int t;
        t = int'(v);
        return longint'(t);
    endfunction

    // Reference escape-time computation in plain integer arithmetic.
    function automatic void model(input logic [31:0] cr_in, input logic [31:0] ci_in,
                                  output int cnt, output bit esc);
        longint zr, zi, sr, si, pr, cr, ci, nzr, nzi;
        zr = 0; zi = 0;
        cr = longint'(signed'(cr_in));
        ci = longint'(signed'(ci_in));
        cnt = MAX_ITER; esc = 1'b0;
        for (int k = 0; k <= MAX_ITER; k++) begin
            sr = (zr * zr) >>> 21;
            si = (zi * zi) >>> 21;
            if (sr + si > 4 * ONE) begin
                cnt = k; esc = 1'b1;
                return;
            end
            if (k == MAX_ITER) begin
                cnt = MAX_ITER; esc = 1'b0;
                return;
            end
            pr  = (zr * zi) >>> 21;
            nzr = sr - si + cr;
            nzi = 2 * pr + ci;
            zr  = wrap32(nzr);
            zi  = wrap32(nzi);
        end
    endfunction

    // Present a point and return at the negedge after the accept edge.
    task automatic send(input logic [31:0] cr, input logic [31:0] ci,
                        input logic [9:0] x, input logic [9:0] y,
                        input logic l, input bit expect_result);
        exp_t e;
        int   n;
        if (expect_result) begin
            model(cr, ci, e.cnt, e.esc);
            e.x = x; e.y = y; e.last = l;
            sb_q.push_back(e);
        end
        @(negedge clock);
        c_re = cr; c_im = ci; x_in = x; y_in = y; last_in = l;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 2000) begin
            errors++;
            $display("FAIL accept_timeout: in_ready never rose");
        end
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // Wait for scoreboard to empty, optionally throttling out_ready.
    task automatic drain(input bit throttle);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 5000) begin
            @(negedge clock);
            out_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("drain_done", longint'(sb_q.size() == 0 && in_ready), 64'sd1);
    endtask

    // Monitor: compare each presented result once against the scoreboard head.
    initial begin
        bit   seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clock);
            if (!rst && out_valid && !seen) begin
                seen = 1'b1;
                if (sb_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_result: cnt=%0d with empty scoreboard", iter_cnt);
                end else begin
                    e = sb_q.pop_front();
                    chk("iter_cnt", longint'(iter_cnt), longint'(e.cnt));
                    chk("escaped",  longint'(escaped),  longint'(e.esc));
                    chk("x_out",    longint'(x_out),    longint'(e.x));
                    chk("y_out",    longint'(y_out),    longint'(e.y));
                    chk("last_out", longint'(last_out), longint'(e.last));
                end
            end else if (!out_valid) begin
                seen = 1'b0;
            end
        end
    end

    initial begin
        int lat;
        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_in_ready",  longint'(in_ready),  64'sd1);
        chk("rst_out_valid", longint'(out_valid), 64'sd0);
        chk("rst_iter_cnt",  longint'(iter_cnt),  64'sd0);
        chk("rst_escaped",   longint'(escaped),   64'sd0);
        chk("rst_xyl",       longint'({x_out, y_out, last_out}), 64'sd0);
        rst = 1'b0;

        // 1: c = 0 runs to the cap; measure latency including the accept edge
        out_ready = 1'b1;
        send(32'h0000_0000, 32'h0000_0000, 10'd1, 10'd2, 1'b0, 1'b1);
        lat = 1;
        while (!out_valid && lat < 1000) begin
            @(negedge clock);
            lat++;
        end
        chk("latency_c0", longint'(lat), 64'sd257);
        drain(1'b0);

        // 2..4: short escape, z = 0,1,2,5 and the exact-4.0 boundary
        send(32'h0060_0000, 32'h0000_0000, 10'd3, 10'd4, 1'b0, 1'b1);
        drain(1'b0);
        send(32'h0020_0000, 32'h0000_0000, 10'd5, 10'd6, 1'b0, 1'b1);
        drain(1'b0);
        send(32'hFFC0_0000, 32'h0000_0000, 10'd7, 10'd8, 1'b0, 1'b1);
        drain(1'b0);

        // 5: back-pressure holds every field; in_valid while busy is ignored
        out_ready = 1'b0;
        send(32'h0060_0000, 32'h0000_0000, 10'd639, 10'd479, 1'b1, 1'b1);
        lat = 0;
        while (!out_valid && lat < 1000) begin
            @(negedge clock);
            lat++;
        end
        c_re = 32'h0020_0000; x_in = 10'd11; y_in = 10'd12; last_in = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("hold_out_valid", longint'(out_valid), 64'sd1);
            chk("hold_in_ready",  longint'(in_ready),  64'sd0);
            chk("hold_iter_cnt",  longint'(iter_cnt),  64'sd1);
            chk("hold_escaped",   longint'(escaped),   64'sd1);
            chk("hold_xyl",       longint'({x_out, y_out, last_out}),
                longint'({10'd639, 10'd479, 1'b1}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        chk("release_in_ready",  longint'(in_ready),  64'sd1);
        chk("release_out_valid", longint'(out_valid), 64'sd0);
        chk("release_xyl",       longint'({x_out, y_out, last_out}),
            longint'({10'd639, 10'd479, 1'b1}));
        chk("release_sb_empty",  longint'(sb_q.size()), 64'sd0);

        // 6: reset mid-iteration discards the point
        send(32'h0000_0000, 32'h0000_0000, 10'd100, 10'd200, 1'b1, 1'b0);
        repeat (50) @(negedge clock);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", longint'(out_valid), 64'sd0);
        chk("midrst_in_ready",  longint'(in_ready),  64'sd1);
        chk("midrst_iter_cnt",  longint'(iter_cnt),  64'sd0);
        chk("midrst_escaped",   longint'(escaped),   64'sd0);
        chk("midrst_xyl",       longint'({x_out, y_out, last_out}), 64'sd0);
        @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        chk("postrst_in_ready", longint'(in_ready), 64'sd1);
        send(32'h0020_0000, 32'h0000_0000, 10'd9, 10'd10, 1'b0, 1'b1);
        drain(1'b0);

        // Random points with random downstream back-pressure
        for (int i = 0; i < 24; i++) begin
            logic [31:0] rc, ic;
            rc = $urandom_range(0, 7340032) - 32'd5242880;
            ic = $urandom_range(0, 6291456) - 32'd3145728;
            send(rc, ic, 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                 1'($urandom_range(0, 1)), 1'b1);
            drain(1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
